// File: rtl/fir_out_stage.sv
// fir_out_stage: final stage of the FIR accumulator chain.
// It scales the signed accumulator with an arithmetic right shift and
// saturates the result to OUT_WIDTH. Samples go into a 2-deep {tlast, data}
// FIFO that drives an AXI-Stream master.
// Define FIR_OUT_ROUND_EN for round-half-up. Leave it undefined to truncate
// toward negative infinity.
module fir_out_stage #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int FRAME_LEN = 64
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 acc_valid_i,
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic                 acc_ready_o,
  output logic [OUT_WIDTH-1:0] m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  input  logic                 m_axis_tready_i,
  output logic                 m_axis_tlast_o,
  input  logic                 clr_i,
  output logic                 sat_o
);

  typedef struct packed {
    logic                 last;
    logic [OUT_WIDTH-1:0] data;
  } entry_t;

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] FLAST = CW'(FRAME_LEN - 1);
  localparam logic signed [ACC_WIDTH:0] MAXV =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  entry_t [1:0]              mem;
  logic                      wr_ptr, rd_ptr;
  logic [1:0]                count, count_nxt;
  logic [CW-1:0]             fcnt;
  logic                      push, pop, sat_hi, sat_lo;
  logic signed [ACC_WIDTH:0] acc_ext, acc_rnd, scaled;
  entry_t                    wr_ent;

  assign push = acc_valid_i & acc_ready_o;
  assign pop  = m_axis_tvalid_o & m_axis_tready_i;

  // One extra bit of headroom keeps the rounding carry from wrapping
  assign acc_ext = {acc_i[ACC_WIDTH-1], acc_i};
`ifdef FIR_OUT_ROUND_EN
  localparam logic [ACC_WIDTH:0] RND = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  assign acc_rnd = acc_ext + $signed(RND);
`else
  assign acc_rnd = acc_ext;
`endif
  assign scaled = acc_rnd >>> SHIFT;
  assign sat_hi = scaled > MAXV;
  assign sat_lo = scaled < MINV;

  // Build the entry to push, clamped to OUT_WIDTH, tagged with frame end
  always_comb begin
    wr_ent.last = (fcnt == FLAST);
    if (sat_hi)      wr_ent.data = MAXV[OUT_WIDTH-1:0];
    else if (sat_lo) wr_ent.data = MINV[OUT_WIDTH-1:0];
    else             wr_ent.data = scaled[OUT_WIDTH-1:0];
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // FIFO storage, pointers, and a registered ready (no tready->ready path)
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mem         <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      acc_ready_o <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_ent;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count       <= count_nxt;
      acc_ready_o <= (count_nxt < 2'd2);
    end
  end

  // Frame position and sticky saturation; a saturating push beats clr_i
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      fcnt  <= '0;
      sat_o <= 1'b0;
    end else begin
      if (clr_i)     fcnt <= '0;
      else if (push) fcnt <= (fcnt == FLAST) ? '0 : fcnt + CW'(1);
      if (push && (sat_hi || sat_lo)) sat_o <= 1'b1;
      else if (clr_i)                 sat_o <= 1'b0;
    end
  end

  assign m_axis_tvalid_o = (count != 2'd0);
  assign m_axis_tdata_o  = mem[rd_ptr].data;
  assign m_axis_tlast_o  = mem[rd_ptr].last;

endmodule

// File: tb/tb_fir_out_stage.sv
// Bench for fir_out_stage (FRAME_LEN=4). A queue model tracks FIFO contents,
// ready, sat, and frame position. Every negedge compares DUT against it.
module tb_fir_out_stage;
  localparam int FL = 4;

  logic        clk_i = 1'b0, arstn_i = 1'b1;
  logic        acc_valid_i = 1'b0, m_axis_tready_i = 1'b1, clr_i = 1'b0;
  logic [31:0] acc_i = '0;
  logic        acc_ready_o, m_axis_tvalid_o, m_axis_tlast_o, sat_o;
  logic [15:0] m_axis_tdata_o;

  fir_out_stage #(.ACC_WIDTH(32), .OUT_WIDTH(16), .SHIFT(15), .FRAME_LEN(FL)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .acc_valid_i(acc_valid_i), .acc_i(acc_i),
    .acc_ready_o(acc_ready_o), .m_axis_tdata_o(m_axis_tdata_o),
    .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tready_i(m_axis_tready_i),
    .m_axis_tlast_o(m_axis_tlast_o), .clr_i(clr_i), .sat_o(sat_o));

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;
  bit rnd_rdy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: floor(acc/2^15) (optionally +0.5), clamped; returns {sat, data}
  function automatic logic [16:0] ref_out(input logic [31:0] a);
    longint v;
    logic   s;
    v = longint'($signed(a));
`ifdef FIR_OUT_ROUND_EN
    v = v + 64'sd16384;
`endif
    v = v >>> 15;
    s = 1'b0;
    if (v > 32767)       begin v = 32767;  s = 1'b1; end
    else if (v < -32768) begin v = -32768; s = 1'b1; end
    return {s, v[15:0]};
  endfunction

  // Model state
  logic [16:0] q[$];
  logic [16:0] plog[$];
  logic        rdy_m, sat_m, p_push, p_pop, lst;
  logic [16:0] r;
  int          nfr;

  always @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      q.delete(); rdy_m = 0; sat_m = 0; nfr = 0;
    end else begin
      if (m_axis_tvalid_o && m_axis_tready_i) plog.push_back({m_axis_tlast_o, m_axis_tdata_o});
      p_push = acc_valid_i && rdy_m;
      p_pop  = (q.size() != 0) && m_axis_tready_i;
      r   = ref_out(acc_i);
      lst = ((nfr % FL) == FL - 1);
      if (p_push && r[16]) sat_m = 1;
      else if (clr_i)      sat_m = 0;
      if (clr_i)       nfr = 0;
      else if (p_push) nfr++;
      if (p_pop)  void'(q.pop_front());
      if (p_push) q.push_back({lst, r[15:0]});
      rdy_m = (q.size() < 2);
    end
  end

  // Cycle compare
  always @(negedge clk_i) begin
    chk("ready", acc_ready_o, rdy_m);
    chk("tvalid", m_axis_tvalid_o, q.size() != 0);
    chk("sat", sat_o, sat_m);
    if (q.size() != 0) begin
      chk("tdata", m_axis_tdata_o, q[0][15:0]);
      chk("tlast", m_axis_tlast_o, q[0][16]);
    end
    if (!arstn_i) begin
      chk("rst_tdata", m_axis_tdata_o, 0);
      chk("rst_tlast", m_axis_tlast_o, 0);
    end
  end

  task automatic send(input logic [31:0] v, input logic [15:0] e, input string nm);
    @(negedge clk_i);
    acc_valid_i = 1; acc_i = v;
    @(posedge clk_i); #1;
    chk({nm, "_data"}, m_axis_tdata_o, e);
    chk({nm, "_vld"}, m_axis_tvalid_o, 1);
    @(negedge clk_i);
    acc_valid_i = 0;
    @(posedge clk_i); #1;
    chk({nm, "_vld_off"}, m_axis_tvalid_o, 0);
  endtask

  // Starts and ends at a negedge; holds valid until the stage accepts
  task automatic push_wait(input logic [31:0] v);
    bit ok;
    ok = 0;
    acc_valid_i = 1; acc_i = v;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (rnd_rdy) m_axis_tready_i = ($urandom_range(0, 1) == 1);
      ok = acc_ready_o;
      @(negedge clk_i);
    end
    chk("push_accept", ok, 1);
  endtask

  function automatic logic [31:0] rnd_acc();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 3))
      0: rnd_acc = x;
      1: rnd_acc = {{10{x[21]}}, x[21:0]};
      2: rnd_acc = 32'h3FFF_C000 + $urandom_range(0, 32'h8000);
      default: rnd_acc = 32'hC000_0000 - $urandom_range(0, 32'h8000);
    endcase
  endfunction

  initial begin
    #2 arstn_i = 0;
    #1;
    chk("rst_ready", acc_ready_o, 0);
    chk("rst_tvalid", m_axis_tvalid_o, 0);
    chk("rst_sat", sat_o, 0);
    repeat (3) @(negedge clk_i);
    arstn_i = 1;
    #1 chk("ready_at_release", acc_ready_o, 0);
    @(posedge clk_i); #1;
    chk("ready_after_release", acc_ready_o, 1);

    // Scaling / saturation literals
    send(32'h0000_8000, 16'h0001, "one");
    chk("sat_clean", sat_o, 0);
    send(32'h4000_0000, 16'h7FFF, "satpos");
    chk("sat_set", sat_o, 1);
    send(32'hC000_0000, 16'h8000, "minneg");
`ifdef FIR_OUT_ROUND_EN
    send(32'h0000_4000, 16'h0001, "half");
    send(32'hFFFF_C000, 16'h0000, "neghalf");
`else
    send(32'h0000_4000, 16'h0000, "half");
    send(32'hFFFF_C000, 16'hFFFF, "neghalf");
`endif

    // Stall: two entries fill the FIFO, ready drops, head holds
    @(negedge clk_i);
    m_axis_tready_i = 0;
    plog.delete();
    push_wait(32'd1 << 15);
    push_wait(32'd2 << 15);
    chk("stall_ready", acc_ready_o, 0);
    acc_valid_i = 1; acc_i = 32'd3 << 15;
    repeat (3) begin
      @(negedge clk_i);
      chk("stall_hold", m_axis_tdata_o, 16'h0001);
    end
    m_axis_tready_i = 1;
    push_wait(32'd3 << 15);
    push_wait(32'd4 << 15);
    acc_valid_i = 0;
    repeat (5) @(negedge clk_i);
    chk("stall_n", plog.size(), 4);
    for (int i = 0; i < 4 && i < plog.size(); i++)
      chk("stall_order", plog[i][15:0], i + 1);

    // Frames of 4 under random tready, clear after sample 9
    clr_i = 1;
    @(negedge clk_i);
    clr_i = 0;
    plog.delete();
    rnd_rdy = 1;
    for (int i = 1; i <= 9; i++) push_wait((i == 5) ? 32'h7FFF_FFFF : (i << 15));
    acc_valid_i = 0;
    clr_i = 1;
    @(negedge clk_i);
    clr_i = 0;
    for (int i = 10; i <= 13; i++) push_wait(i << 15);
    acc_valid_i = 0;
    rnd_rdy = 0;
    m_axis_tready_i = 1;
    repeat (5) @(negedge clk_i);
    chk("frame_n", plog.size(), 13);
    for (int i = 0; i < 13 && i < plog.size(); i++) begin
      chk("frame_tlast", plog[i][16], (i == 3 || i == 7 || i == 12));
      chk("frame_data", plog[i][15:0], (i == 4) ? 32'h7FFF : (i + 1));
    end
    chk("sat_cleared", sat_o, 0);

    // Reset with two samples buffered
    m_axis_tready_i = 0;
    push_wait(32'd5 << 15);
    push_wait(32'd6 << 15);
    acc_valid_i = 0;
    plog.delete();
    #3 arstn_i = 0;
    #1;
    chk("midrst_tvalid", m_axis_tvalid_o, 0);
    chk("midrst_tdata", m_axis_tdata_o, 0);
    chk("midrst_ready", acc_ready_o, 0);
    @(negedge clk_i);
    arstn_i = 1;
    m_axis_tready_i = 1;
    repeat (5) @(negedge clk_i);
    chk("midrst_nostale", plog.size(), 0);

    // Random traffic
    repeat (800) begin
      acc_valid_i     = ($urandom_range(0, 1) == 1);
      acc_i           = rnd_acc();
      m_axis_tready_i = ($urandom_range(0, 3) != 0);
      clr_i           = ($urandom_range(0, 31) == 0);
      @(negedge clk_i);
    end
    acc_valid_i = 0; clr_i = 0;
    repeat (3) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_out_stage.md
Name: fir_out_stage

Overview:
- Output stage directly downstream of the last tap cell of the FIR accumulator chain.
- Takes the full-width signed accumulator result, then scales it by an arithmetic right shift with optional rounding.
- Saturates the scaled value to the output width and buffers it in a 2-entry FIFO.
- Presents samples as an AXI-Stream master with frame tlast; drives acc_ready_o back to gate the chain enable.

Parameters:
- ACC_WIDTH, 32: width of accumulator input (signed).
- OUT_WIDTH, 16: width of output sample (signed); must be < ACC_WIDTH - SHIFT + 1.
- SHIFT, 15: arithmetic right shift applied to the accumulator (coefficient Q-format); must be >= 1.
- FRAME_LEN, 64: samples per frame; m_axis_tlast_o marks the last sample of each frame; >= 1.

Ports:
- clk_i  in  1  clock.
- arstn_i  in  1  asynchronous active-low reset.
- acc_valid_i  in  1  accumulator result valid (chain enable was active).
- acc_i  in  ACC_WIDTH  signed accumulator result from the last tap.
- acc_ready_o  out  1  stage can accept; upstream ANDs it into the tap enable.
- m_axis_tdata_o  out  OUT_WIDTH  signed output sample.
- m_axis_tvalid_o  out  1  output valid.
- m_axis_tready_i  in  1  downstream ready.
- m_axis_tlast_o  out  1  last sample of frame.
- clr_i  in  1  synchronous clear of the sticky saturation flag and the frame counter.
- sat_o  out  1  sticky: at least one sample saturated since reset or last clr_i.

Behaviour:
- Reset (async, active-low): FIFO empty (count=0), rd/wr pointers 0, acc_ready_o=0, m_axis_tvalid_o=0, m_axis_tdata_o=0, m_axis_tlast_o=0, sat_o=0, frame counter=0.
- Push = acc_valid_i & acc_ready_o. Pop = m_axis_tvalid_o & m_axis_tready_i.
- Scaling (combinational, ACC_WIDTH+1 bits):
  - Without rounding: s = acc_i >>> SHIFT.
  - With rounding: s = (acc_i + 2^(SHIFT-1)) >>> SHIFT.
- Saturation:
  - s > 2^(OUT_WIDTH-1)-1 -> max positive.
  - s < -2^(OUT_WIDTH-1) -> min negative.
  - Otherwise s truncated to OUT_WIDTH.
  - On a push with a saturated value, sat_o sets to 1 next cycle.
- FIFO: depth 2; each entry stores {tlast, data}; the head drives the m_axis outputs directly; m_axis_tvalid_o = (count != 0).
- acc_ready_o is registered: next value = (count_next < 2); it is 1 from the first clock edge after reset release.
  - There is no combinational path from m_axis_tready_i to acc_ready_o.
  - Because acc_ready_o only rises after a pop has occurred, full-buffer throughput is 1 sample per cycle except the cycle after a full stall.
- Count update:
  - Push and pop in the same cycle: count unchanged, data streams through.
  - Push only: count+1. Pop only: count-1.
  - Push while full is impossible because acc_ready_o=0; any acc_valid_i while not ready is ignored and the sample is lost by upstream contract (the chain does not advance).
- Latency: a sample pushed at edge N with the FIFO empty is valid on m_axis at edge N (visible in cycle N+1), i.e. 1 cycle.
- AXIS rules: while m_axis_tvalid_o=1 and m_axis_tready_i=0, tdata and tlast hold stable.
- Frame counter: counts pushes 0..FRAME_LEN-1.
  - The pushed entry gets tlast=1 when counter==FRAME_LEN-1; the counter then wraps to 0.
  - FRAME_LEN=1 -> every sample has tlast.
- clr_i: sat_o<=0 and frame counter<=0 on the next edge.
  - If a push coincides with clr_i, that push uses the pre-clear counter value for tlast.
  - A saturation on the same push still sets sat_o (set wins over clear).
  - FIFO contents are unaffected.
- Reset mid-operation: buffered samples are discarded; outputs return to reset values immediately.

Optional Feature:
- FIR_OUT_ROUND_EN defined: round-half-up (add 2^(SHIFT-1) before shift), with overflow from rounding caught by saturation.
- Not defined: pure truncation toward negative infinity (plain arithmetic shift).

Test Plan:
- Reset then idle with m_axis_tready_i=1: acc_ready_o=0 during reset, 1 one cycle after release; tvalid=0, sat_o=0.
- acc_i=0x0000_8000 push, tready=1 -> tdata=0x0001 next cycle, tvalid high 1 cycle; acc_i=0x4000_0000 -> tdata=0x7FFF, sat_o=1; acc_i=0xC000_0000 -> tdata=0x8000.
- acc_i=0x0000_4000 -> tdata 0x0001 with FIR_OUT_ROUND_EN, 0x0000 without; acc_i=0xFFFF_C000 -> 0x0000 with, 0xFFFF without.
- Continuous pushes of 1,2,3,4 (acc_i=n<<15) with tready=0: acc_ready_o drops after 2 pushes, tdata holds 1. Then tready=1 -> outputs 1,2,3,4 in order, none lost or duplicated.
- FRAME_LEN=4, 10 samples at full rate, random tready: tlast on samples 4 and 8 only. clr_i after sample 9 -> next sample starts a new frame, and sat_o clears.
- Assert arstn_i with 2 samples buffered -> tvalid=0 immediately; after release no stale sample appears.
